// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
//
// Merges one-cycle press pulses from several debouncers into a single ordered
// event stream. Each button has a pending bit. A round-robin arbiter grants at
// most one pending button per cycle into a small event FIFO. The FIFO head is
// offered to the consumer through a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   btn_pressed  [NUM_BTNS-1:0] one-cycle press pulses, bit i from debouncer i
//   evt_valid    FIFO head holds an event
//   evt_idx      [IDX_W-1:0] button index of the head event (0 when invalid)
//   evt_ready    consumer accepts the head event this cycle
//   fifo_count   [clog2(FIFO_DEPTH):0] occupied FIFO entries
//   overflow     sticky: a press merged into an already pending press
module btn_event_arbiter #(
  parameter int NUM_BTNS   = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BTNS-1:0]           btn_pressed,
  output logic                          evt_valid,
  output logic [IDX_W-1:0]              evt_idx,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W:0]   NUM_C    = (IDX_W + 1)'(NUM_BTNS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_BTNS - 1);

  // Control state
  logic [NUM_BTNS-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]    last_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q;

  // Event storage (data only, never reset)
  logic [IDX_W-1:0]    mem_q [FIFO_DEPTH];

  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NUM_BTNS-1:0] gnt_oh;
  logic [IDX_W:0]      cand;
  logic                push, pop, coalesce;

  assign evt_valid  = (count_q != '0);
  assign evt_idx    = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  // Round-robin search from last_q+1. Scanning the offsets from farthest to
  // nearest and overwriting leaves the nearest set pending bit as the winner.
  // The full test uses the registered count, so a same-cycle pop never frees
  // a slot for a grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = '0;
    if ((pend_q != '0) && (count_q < DEPTH_C)) begin
      for (int k = NUM_BTNS; k >= 1; k--) begin
        cand = {1'b0, last_q} + (IDX_W + 1)'(k);
        if (cand >= NUM_C) cand = cand - NUM_C;
        if (pend_q[cand[IDX_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[IDX_W-1:0];
        end
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  assign push     = gnt_vld;
  assign pop      = evt_valid & evt_ready;
  // A pulse on a bit being granted this cycle becomes a fresh event, not a merge.
  assign pend_d   = (pend_q & ~gnt_oh) | btn_pressed;
  assign coalesce = |(btn_pressed & pend_q & ~gnt_oh);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      last_q   <= LAST_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
      if (gnt_vld)  last_q   <= gnt_idx;
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      if (coalesce) ovf_q    <= 1'b1;
    end
  end

  // Entry contents are qualified by count_q, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= gnt_idx;
  end

endmodule
